// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side master: issues reads, absorbs the one-cycle FIFO read latency
// through a 3-entry skid buffer, and presents the words on a valid/ready stream.
//
// state  | meaning
// IDLE   | not fetching, buffer empty, nothing in flight
// ACTIVE | fetching from the FIFO while enable is high
// DRAIN  | enable dropped; finish in-flight capture and empty the buffer
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  busy,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [FIFO_WIDTH-1:0] buf_q [3];
    logic [1:0]            head_q, tail_q;
    logic [1:0]            cnt_q;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  words_q;
    logic                  err_q;
    logic                  push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Space check counts the in-flight word so a stall can never overfill the buffer.
    assign fifo_rd_en = rst_n & enable & ~fifo_empty &
                        (({1'b0, cnt_q} + {2'b00, inflight_q}) <= 3'd2);

    assign push          = inflight_q;
    assign m_valid       = (cnt_q != 2'd0);
    assign pop           = m_valid & m_ready;
    assign m_data        = buf_q[head_q];
    assign words_out     = words_q;
    assign err_underflow = err_q;
    assign busy          = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!enable) state_d = (cnt_q != 2'd0 || inflight_q) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (enable)                             state_d = S_ACTIVE;
                else if (cnt_q == 2'd0 && !inflight_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            words_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            if (push) begin
                buf_q[tail_q] <= fifo_data_out;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q  <= ptr_inc(head_q);
                words_q <= words_q + CNT_WIDTH'(1);
            end
            if (push && !pop)      cnt_q <= cnt_q + 2'd1;
            else if (!push && pop) cnt_q <= cnt_q - 2'd1;
            if (fifo_underflow) err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && cnt_q == 2'd3))
                else $error("skid buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural registered-read FIFO.
module tb_fifo_rd_stream_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_underflow;
    logic        m_ready;
    logic        fifo_rd_en;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        m_valid;
    logic [15:0] m_data;
    logic [15:0] words_out;
    logic        busy;
    logic        err_underflow;

    logic        w_en;
    logic        w_rd_en, w_valid, w_busy, w_err;
    logic [15:0] w_data;
    logic [3:0]  w_words;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .words_out(words_out), .busy(busy),
        .err_underflow(err_underflow)
    );

    // Narrow counter instance, fed by an always-full source, to exercise wrap-around.
    fifo_rd_stream_adapter #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(w_en), .fifo_empty(1'b0),
        .fifo_data_out(16'hABCD), .fifo_underflow(1'b0),
        .fifo_rd_en(w_rd_en), .m_valid(w_valid), .m_ready(1'b1),
        .m_data(w_data), .words_out(w_words), .busy(w_busy),
        .err_underflow(w_err)
    );

    // Behavioural FIFO with registered read data.
    logic [15:0] fmem [16];
    logic [4:0]  fcnt = '0;
    logic [3:0]  frp = '0, fwp = '0;
    logic        fpush, fclr;
    logic [15:0] fpush_data;
    logic [15:0] fdout = '0;
    logic        frd;

    assign fifo_empty    = (fcnt == 5'd0);
    assign fifo_data_out = fdout;
    assign frd           = fifo_rd_en && (fcnt != 5'd0);

    always @(posedge clk) begin
        if (fclr) begin
            fcnt <= '0;
            frp  <= '0;
            fwp  <= '0;
        end else begin
            if (fpush) begin
                fmem[fwp] <= fpush_data;
                fwp       <= fwp + 4'd1;
            end
            if (frd) begin
                fdout <= fmem[frp];
                frp   <= frp + 4'd1;
            end
            fcnt <= fcnt + 5'(fpush) - 5'(frd);
        end
    end

    // Monitor: record handshakes and read requests sampled mid-cycle.
    int          cyc = 0;
    logic [15:0] rx_q[$];
    int          hs_cyc_q[$];
    int          rd_cyc_q[$];
    int          v_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                rx_q.push_back(m_data);
                hs_cyc_q.push_back(cyc);
            end
            if (fifo_rd_en) rd_cyc_q.push_back(cyc);
            if (m_valid) v_total++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        fpush      = 1'b1;
        fpush_data = d;
        step(1);
        fpush      = 1'b0;
    endtask

    int qb, rb, vb;

    initial begin
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
        fpush = 1'b0; fpush_data = '0; fclr = 1'b1; w_en = 1'b0;
        step(3);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        fclr = 1'b0; rst_n = 1'b1;
        step(1);
        check("rst_words_out", 32'(words_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);

        // 1: full-rate burst of 8 words
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        qb = rx_q.size(); rb = rd_cyc_q.size();
        enable = 1'b1; m_ready = 1'b1;
        step(14);
        check("t1_count", 32'(rx_q.size() - qb), 32'd8);
        for (int i = 0; i < 8; i++)
            if (qb + i < rx_q.size()) check("t1_word", 32'(rx_q[qb + i]), 32'(i + 1));
        if (rx_q.size() - qb >= 8 && rd_cyc_q.size() > rb) begin
            check("t1_latency", 32'(hs_cyc_q[qb] - rd_cyc_q[rb]), 32'd2);
            check("t1_throughput", 32'(hs_cyc_q[qb + 7] - hs_cyc_q[qb]), 32'd7);
        end
        check("t1_words_out", 32'(words_out), 32'd8);
        enable = 1'b0;
        step(2);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: downstream stall holds three words
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        qb = rx_q.size(); rb = rd_cyc_q.size();
        m_ready = 1'b0; enable = 1'b1;
        step(4);
        check("t2_head_early", 32'(m_data), 32'h1);
        step(6);
        check("t2_reads", 32'(rd_cyc_q.size() - rb), 32'd3);
        check("t2_valid", 32'(m_valid), 32'd1);
        check("t2_head_stable", 32'(m_data), 32'h1);
        check("t2_fifo_cnt", 32'(fcnt), 32'd5);
        m_ready = 1'b1;
        step(12);
        check("t2_count", 32'(rx_q.size() - qb), 32'd8);
        for (int i = 0; i < 8; i++)
            if (qb + i < rx_q.size()) check("t2_word", 32'(rx_q[qb + i]), 32'(i + 1));
        check("t2_words_out", 32'(words_out), 32'd16);
        enable = 1'b0;
        step(2);

        // 3: enabled against an empty FIFO
        rb = rd_cyc_q.size(); vb = v_total;
        enable = 1'b1;
        step(20);
        check("t3_no_reads", 32'(rd_cyc_q.size() - rb), 32'd0);
        check("t3_no_valid", 32'(v_total - vb), 32'd0);
        check("t3_err", 32'(err_underflow), 32'd0);
        enable = 1'b0;
        step(2);

        // 4: drop enable after two reads, drain
        for (int i = 0; i < 5; i++) push_word(16'h11 + 16'(i));
        qb = rx_q.size(); rb = rd_cyc_q.size();
        enable = 1'b1; m_ready = 1'b1;
        step(2);
        enable = 1'b0;
        step(1);
        check("t4_drain_busy", 32'(busy), 32'd1);
        step(3);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_reads", 32'(rd_cyc_q.size() - rb), 32'd2);
        check("t4_count", 32'(rx_q.size() - qb), 32'd2);
        if (rx_q.size() - qb >= 2) begin
            check("t4_word0", 32'(rx_q[qb]), 32'h11);
            check("t4_word1", 32'(rx_q[qb + 1]), 32'h12);
        end
        check("t4_fifo_cnt", 32'(fcnt), 32'd3);

        // 5: reset with two buffered and one in flight
        push_word(16'h16);
        push_word(16'h17);
        m_ready = 1'b0; enable = 1'b1;
        step(3);
        check("t5_pre_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0; enable = 1'b0;
        #1;
        check("t5_rst_valid", 32'(m_valid), 32'd0);
        check("t5_rst_words", 32'(words_out), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        qb = rx_q.size();
        m_ready = 1'b1; enable = 1'b1;
        step(8);
        check("t5_count", 32'(rx_q.size() - qb), 32'd2);
        if (rx_q.size() - qb >= 2) begin
            check("t5_word0", 32'(rx_q[qb]), 32'h16);
            check("t5_word1", 32'(rx_q[qb + 1]), 32'h17);
        end
        check("t5_words_out", 32'(words_out), 32'd2);
        enable = 1'b0;
        step(2);

        // 6: sticky underflow, then counter wrap on the narrow instance
        fifo_underflow = 1'b1;
        step(1);
        fifo_underflow = 1'b0;
        check("t6_err_set", 32'(err_underflow), 32'd1);
        step(5);
        check("t6_err_held", 32'(err_underflow), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_err_rst", 32'(err_underflow), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        w_en = 1'b1;
        for (int i = 0; i < 40 && w_words != 4'hF; i++) step(1);
        check("t6_wrap_pre", 32'(w_words), 32'hF);
        check("t6_wrap_valid", 32'(w_valid), 32'd1);
        step(1);
        check("t6_wrap_zero", 32'(w_words), 32'h0);
        w_en = 1'b0;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
